// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32IM core
// Owns the architectural PC, the retired-instruction counter and the handshake stall watchdog.
module core_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MAX_STALL = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        start_i,
   input  logic        imem_ready_i,
   input  logic        exec_done_i,
   input  logic        is_mem_op_i,
   input  logic        dmem_ready_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        halt_req_i,
   output logic        fetch_enabled_o,
   output logic        decoder_enabled_o,
   output logic        exec_enabled_o,
   output logic        mem_enabled_o,
   output logic        wb_enabled_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_cnt_o,
   output logic        busy_o,
   output logic        halted_o,
   output logic        timeout_o
);

   localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);
   localparam bit WATCHDOG_ON = (MAX_STALL > 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               exec_started_q;
   logic               wait_state;
   logic               exit_ok;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q        <= S_IDLE;
         pc_q           <= RESET_PC;
         cnt_q          <= 32'd0;
         timeout_q      <= 1'b0;
         stall_q        <= '0;
         exec_started_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         cnt_q          <= cnt_d;
         timeout_q      <= timeout_d;
         stall_q        <= stall_d;
         exec_started_q <= (state_q == S_EXEC);
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      stall_d    = stall_q;
      wait_state = 1'b0;
      exit_ok    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            wait_state = 1'b1;
            exit_ok    = imem_ready_i;
            if (imem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            wait_state = 1'b1;
            exit_ok    = exec_done_i;
            if (exec_done_i) state_d = is_mem_op_i ? S_MEM : S_WB;
         end
         S_MEM: begin
            wait_state = 1'b1;
            exit_ok    = dmem_ready_i;
            if (dmem_ready_i) state_d = S_WB;
         end
         S_WB: begin
            pc_d    = branch_taken_i ? branch_target_i : pc_q + 32'd4;
            cnt_d   = cnt_q + 32'd1;
            state_d = halt_req_i ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (start_i) begin
               state_d   = S_FETCH;
               pc_d      = RESET_PC;
               cnt_d     = 32'd0;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A handshake in the limit cycle sets exit_ok, so it always beats the timeout.
      if (WATCHDOG_ON && wait_state && !exit_ok) begin
         if (stall_q == STALL_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
         end else begin
            stall_d = stall_q + STALL_W'(1);
         end
      end

      if (state_d != state_q) stall_d = '0;
   end

   assign fetch_enabled_o   = (state_q == S_FETCH);
   assign decoder_enabled_o = (state_q == S_DECODE);
   assign exec_enabled_o    = (state_q == S_EXEC) && !exec_started_q;
   assign mem_enabled_o     = (state_q == S_MEM);
   assign wb_enabled_o      = (state_q == S_WB);
   assign busy_o            = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted_o          = (state_q == S_HALT);
   assign pc_o              = pc_q;
   assign instr_cnt_o       = cnt_q;
   assign timeout_o         = timeout_q;

endmodule
